cla_adder_4bit: RTL and testbench
=================================

// Module: cla_adder_4bit
//
// PURPOSE
//   4-bit carry-lookahead adder with registered outputs. Computes
//   {Cout,S3..S0} = A3..A0 + B3..B0 + Cin.
//   All carries are derived in parallel from bit generate/propagate terms,
//   never by rippling. Group propagate/generate outputs allow cascading
//   into wider adders through an external lookahead unit.
//   Single clock domain; results register on the rising edge.
//
// PARAMETERS
//   None. Width is fixed at 4 bits, with scalar bit-level ports.
//
// PORTS
//   clk    input  1  rising-edge clock
//   rst_n  input  1  asynchronous active-low reset
//   A3     input  1  operand A bit 3 (MSB)
//   A2     input  1  operand A bit 2
//   A1     input  1  operand A bit 1
//   A0     input  1  operand A bit 0 (LSB)
//   B3     input  1  operand B bit 3 (MSB)
//   B2     input  1  operand B bit 2
//   B1     input  1  operand B bit 1
//   B0     input  1  operand B bit 0 (LSB)
//   Cin    input  1  carry in
//   S3     output 1  sum bit 3, registered
//   S2     output 1  sum bit 2, registered
//   S1     output 1  sum bit 1, registered
//   S0     output 1  sum bit 0, registered
//   Cout   output 1  carry out of bit 3, registered
//   PG     output 1  group propagate (P3&P2&P1&P0), registered
//   GG     output 1  group generate, registered
//
// BEHAVIOUR
//   - Bit terms: Gi = Ai&Bi, Pi = Ai^Bi, for i = 0..3. C0 = Cin.
//   - Carries are flat two-level sum-of-products, with no chained carry:
//       C1 = G0 | P0&C0
//       C2 = G1 | P1&G0 | P1&P0&C0
//       C3 = G2 | P2&G1 | P2&P1&G0 | P2&P1&P0&C0
//       C4 = G3 | P3&G2 | P3&P2&G1 | P3&P2&P1&G0 | P3&P2&P1&P0&C0
//   - Si = Pi ^ Ci. Cout = C4.
//   - GG = G3 | P3&G2 | P3&P2&G1 | P3&P2&P1&G0. PG = P3&P2&P1&P0.
//   - Arithmetic is unsigned. The 5-bit result {Cout,S} is exact, so no
//     overflow is lost. Maximum value is 15+15+1 = 31 -> Cout=1, S=1111.
//   - Latency: inputs sampled at rising edge N appear on the outputs after
//     edge N. Exactly 1 cycle, with one new result per cycle and no stalls.
//   - No handshake. Every clock edge captures the current inputs.
//   - Reset: rst_n low immediately forces S3..S0, Cout, PG and GG to 0,
//     independent of clk. Outputs hold 0 while rst_n is low.
//   - Release of rst_n: the first rising edge after release registers the
//     sum of the inputs present at that edge.
//   - Reset mid-operation discards the in-flight result. There is no
//     other internal state.
//   - Inputs may change at any time outside the setup/hold window. Outputs
//     change only on a clk rising edge or on rst_n assertion.
//
// TESTING
//   1. Reset: rst_n=0 with A=1111, B=1111, Cin=1 -> all outputs 0 with no
//      clock edge. Release, one edge -> S=1111, Cout=1.
//   2. Zero: A=0000, B=0000, Cin=0, one edge -> S=0000, Cout=0, PG=0,
//      GG=0.
//   3. Max: A=1111, B=1111, Cin=1, one edge -> S=1111, Cout=1, PG=0,
//      GG=1.
//   4. Mixed: A=1001, B=1111, Cin=0, one edge -> S=1000, Cout=1, GG=1.
//   5. Full propagate: A=1111, B=0000, Cin=1 -> S=0000, Cout=1, PG=1,
//      GG=0. Same with Cin=0 -> S=1111, Cout=0.
//   6. Exhaustive: all 512 {A,B,Cin} combinations back-to-back, one per
//      cycle. Check each result one cycle later against A+B+Cin. Assert
//      rst_n mid-sweep -> outputs 0 at once; sweep resumes correctly after
//      release.

Source files
------------

// File: rtl/cla_adder_4bit.sv
// cla_adder_4bit: 4-bit carry-lookahead adder with registered sum, carry-out and group P/G.
// Revision 1.0
`default_nettype none

module cla_adder_4bit (
  input  logic clk,
  input  logic rst_n,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic Cin,
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0,
  output logic Cout,
  output logic PG,
  output logic GG
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] sum;
  logic       grp_p;
  logic       grp_g;

  assign a = {A3, A2, A1, A0};
  assign b = {B3, B2, B1, B0};
  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum-of-products of bit terms and Cin; none feeds another.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum   = p ^ c[3:0];
  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {S3, S2, S1, S0} <= 4'b0000;
      Cout             <= 1'b0;
      PG               <= 1'b0;
      GG               <= 1'b0;
    end else begin
      {S3, S2, S1, S0} <= sum;
      Cout             <= c[4];
      PG               <= grp_p;
      GG               <= grp_g;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cla_adder_4bit.sv
// tb_cla_adder_4bit: table-driven and exhaustive check of cla_adder_4bit.
`default_nettype none

module tb_cla_adder_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       s3, s2, s1, s0, cout, pg, gg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Packed result layout: {cout, s[3:0], pg, gg}
  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[8];

  cla_adder_4bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A3   (a[3]),
    .A2   (a[2]),
    .A1   (a[1]),
    .A0   (a[0]),
    .B3   (b[3]),
    .B2   (b[2]),
    .B1   (b[1]),
    .B0   (b[0]),
    .Cin  (cin),
    .S3   (s3),
    .S2   (s2),
    .S1   (s1),
    .S0   (s0),
    .Cout (cout),
    .PG   (pg),
    .GG   (gg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] model(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [4:0] total;
    logic [4:0] no_cin;
    total  = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    no_cin = {1'b0, x} + {1'b0, y};
    return {total[4], total[3:0], ((x ^ y) == 4'hF), no_cin[4]};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {cout, s3, s2, s1, s0, pg, gg};
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got {cout,s,pg,gg}=%b, expected %b", name, act, exp);
  endtask

  task automatic apply(input logic [3:0] x, input logic [3:0] y, input logic ci);
    @(negedge clk);
    a   = x;
    b   = y;
    cin = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"zero",         4'b0000, 4'b0000, 1'b0, 7'b0_0000_0_0};
    vecs[1] = '{"max",          4'b1111, 4'b1111, 1'b1, 7'b1_1111_0_1};
    vecs[2] = '{"mixed",        4'b1001, 4'b1111, 1'b0, 7'b1_1000_0_1};
    vecs[3] = '{"prop_cin1",    4'b1111, 4'b0000, 1'b1, 7'b1_0000_1_0};
    vecs[4] = '{"prop_cin0",    4'b1111, 4'b0000, 1'b0, 7'b0_1111_1_0};
    vecs[5] = '{"alt_prop",     4'b0101, 4'b1010, 1'b0, 7'b0_1111_1_0};
    vecs[6] = '{"msb_gen",      4'b1000, 4'b1000, 1'b0, 7'b1_0000_0_1};
    vecs[7] = '{"mid_carry",    4'b0011, 4'b0101, 1'b1, 7'b0_1001_0_0};

    rst_n = 1'b0;
    a     = 4'b1111;
    b     = 4'b1111;
    cin   = 1'b1;
    @(posedge clk);
    #1;
    check("reset_hold", 7'b0);

    // Release between edges; the next edge must capture the max inputs.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_release", 7'b1_1111_0_1);

    // Asynchronous assertion with no clock edge must clear the outputs.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 7'b0);
    @(posedge clk);
    #1;
    check("reset_over_edge", 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_again", 7'b1_1111_0_1);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin);
      check(vecs[i].name, vecs[i].exp);
    end

    for (int i = 0; i < 512; i++) begin
      logic [8:0] idx;
      idx = i[8:0];
      apply(idx[8:5], idx[4:1], idx[0]);
      check($sformatf("sweep_%0d", i), model(idx[8:5], idx[4:1], idx[0]));
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("sweep_reset", 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
